ibex_rf_write_arbiter: RTL and testbench

- Sits in front of the single register file write port (waddr/wdata/we) and is the only block that drives it.
- Merges two write sources into that port:
  - primary: the in-order WB stage; always accepted, highest priority.
  - secondary: long-latency units (divider, late loads); valid/ready handshake, buffered in a small FIFO.
- Also tracks pending buffered writes so ID can stall on RAW hazards.

---
 rtl/ibex_rf_write_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ibex_rf_write_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_write_arbiter
// Purpose  : Sole driver of the register file write port. Merges the in-order
//            WB stage (primary, always wins) with long-latency results
//            (secondary, valid/ready, buffered in a small FIFO). Tracks live
//            buffered writes so ID can stall on RAW hazards.
// Ports    : clk_i/rst_i          clock, asynchronous active-high reset
//            pri_*                primary write (we/waddr/wdata)
//            sec_*                secondary request (valid/ready/waddr/wdata)
//            chk_raddr_a/b_i      ID operand addresses for hazard lookup
//            hazard_a/b_o         live buffered entry targets that operand
//            rf_we/waddr/wdata_o  register file write port
//            count_o              FIFO occupancy (live or killed entries)
//            err_o                illegal RV32E address seen this cycle
// Options  : IBEX_RF_WARB_FWD_EN  adds fwd_valid_a/b_o, fwd_data_a/b_o
// Revision : 1.0 - initial release
// ============================================================================
module ibex_rf_write_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pri_we_i,
  input  logic [4:0]                   pri_waddr_i,
  input  logic [DataWidth-1:0]         pri_wdata_i,
  input  logic                         sec_valid_i,
  output logic                         sec_ready_o,
  input  logic [4:0]                   sec_waddr_i,
  input  logic [DataWidth-1:0]         sec_wdata_i,
  input  logic [4:0]                   chk_raddr_a_i,
  input  logic [4:0]                   chk_raddr_b_i,
  output logic                         hazard_a_o,
  output logic                         hazard_b_o,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [DataWidth-1:0]         rf_wdata_o,
  output logic [$clog2(Depth):0]       count_o,
  output logic                         err_o
`ifdef IBEX_RF_WARB_FWD_EN
  ,
  output logic                         fwd_valid_a_o,
  output logic [DataWidth-1:0]         fwd_data_a_o,
  output logic                         fwd_valid_b_o,
  output logic [DataWidth-1:0]         fwd_data_b_o
`endif
);

  localparam int unsigned c_AW = $clog2(Depth);
  localparam int unsigned c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(Depth);

  // FIFO storage; live is cleared on pop so live implies occupied.
  logic [Depth-1:0]     r_live;
  logic [4:0]           r_addr [Depth];
  logic [DataWidth-1:0] r_data [Depth];
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_CW-1:0]      r_count;

  logic w_run;
  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_pri_ill;
  logic w_sec_ill;
  logic w_pri_act;
  logic w_sec_ok;
  logic w_pop;
  logic w_bypass;
  logic w_enq;

  // Outputs are forced to their reset values while reset is held so the
  // write port goes quiet immediately, not at the next edge.
  assign w_run     = ~rst_i;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign w_ready   = ~w_full;

  assign w_pri_ill = RV32E & pri_we_i & pri_waddr_i[4];
  assign w_sec_ill = RV32E & sec_waddr_i[4];

  assign w_pri_act = w_run & pri_we_i & (pri_waddr_i != 5'd0) & ~w_pri_ill;
  // A secondary worth writing: legal, non-x0, and not shadowed by a younger
  // same-cycle primary write to the same register.
  assign w_sec_ok  = sec_valid_i & w_ready & ~w_sec_ill & (sec_waddr_i != 5'd0)
                     & ~(w_pri_act & (pri_waddr_i == sec_waddr_i));

  assign w_pop     = w_run & ~w_pri_act & ~w_empty;
  assign w_bypass  = w_run & ~w_pri_act & w_empty & w_sec_ok;
  assign w_enq     = w_run & w_sec_ok & ~w_bypass;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_live   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // A younger primary write kills every older buffered write to the
      // same register (WAW).
      if (w_pri_act) begin
        for (int i = 0; i < int'(Depth); i++) begin
          if (r_addr[i] == pri_waddr_i) begin
            r_live[i] <= 1'b0;
          end
        end
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + 1'b1;
      end
      // The enqueue slot is free and never matches the primary address,
      // so it cannot collide with the kill or pop above.
      if (w_enq) begin
        r_live[r_wr_ptr] <= 1'b1;
        r_addr[r_wr_ptr] <= sec_waddr_i;
        r_data[r_wr_ptr] <= sec_wdata_i;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + c_CW'(w_enq) - c_CW'(w_pop);
    end
  end

  // Write port mux: primary, then FIFO head, then same-cycle bypass.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (w_pri_act) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = pri_waddr_i;
      rf_wdata_o = pri_wdata_i;
    end else if (w_pop) begin
      // A killed head still pops, but writes nothing.
      rf_we_o    = r_live[r_rd_ptr];
      rf_waddr_o = r_addr[r_rd_ptr];
      rf_wdata_o = r_data[r_rd_ptr];
    end else if (w_bypass) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = sec_waddr_i;
      rf_wdata_o = sec_wdata_i;
    end
  end

  assign sec_ready_o = rst_i | w_ready;
  assign count_o     = r_count;
  // Accepted-but-dropped secondaries also flag the illegal address.
  assign err_o       = w_run & (w_pri_ill | (sec_valid_i & w_ready & w_sec_ill));

`ifdef IBEX_RF_WARB_FWD_EN
  generate
    begin : g_fwd
      logic                 w_hit_a;
      logic                 w_hit_b;
      logic [c_AW-1:0]      w_sel_a;
      logic [c_AW-1:0]      w_sel_b;
      logic [c_AW-1:0]      w_idx;

      // Walk from oldest (read pointer) to youngest; the last match wins.
      always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
        w_idx   = '0;
        for (int k = 0; k < int'(Depth); k++) begin
          w_idx = r_rd_ptr + c_AW'(k);
          if (r_live[w_idx] && (r_addr[w_idx] == chk_raddr_a_i)) begin
            w_hit_a = 1'b1;
            w_sel_a = w_idx;
          end
          if (r_live[w_idx] && (r_addr[w_idx] == chk_raddr_b_i)) begin
            w_hit_b = 1'b1;
            w_sel_b = w_idx;
          end
        end
      end

      assign fwd_valid_a_o = w_run & w_hit_a & (chk_raddr_a_i != 5'd0);
      assign fwd_valid_b_o = w_run & w_hit_b & (chk_raddr_b_i != 5'd0);
      assign fwd_data_a_o  = r_data[w_sel_a];
      assign fwd_data_b_o  = r_data[w_sel_b];
      // Only stall while the forwarded entry is the head leaving this cycle.
      assign hazard_a_o    = fwd_valid_a_o & w_pop & (w_sel_a == r_rd_ptr);
      assign hazard_b_o    = fwd_valid_b_o & w_pop & (w_sel_b == r_rd_ptr);
    end
  endgenerate
`else
  logic w_hz_a;
  logic w_hz_b;

  always_comb begin
    w_hz_a = 1'b0;
    w_hz_b = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      w_hz_a = w_hz_a | (r_live[i] & (r_addr[i] == chk_raddr_a_i));
      w_hz_b = w_hz_b | (r_live[i] & (r_addr[i] == chk_raddr_b_i));
    end
  end

  assign hazard_a_o = w_run & w_hz_a & (chk_raddr_a_i != 5'd0);
  assign hazard_b_o = w_run & w_hz_b & (chk_raddr_b_i != 5'd0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_rf_write_arbiter
// Purpose  : Self-checking bench for ibex_rf_write_arbiter (Depth=2). A second
//            instance with RV32E=1 shares the stimulus for the x16..x31 cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_write_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        pri_we;
  logic [4:0]  pri_waddr;
  logic [31:0] pri_wdata;
  logic        sec_valid;
  logic [4:0]  sec_waddr;
  logic [31:0] sec_wdata;
  logic [4:0]  chk_a;
  logic [4:0]  chk_b;

  logic        sec_ready, hz_a, hz_b, rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  count;

  logic        e_sec_ready, e_hz_a, e_hz_b, e_rf_we, e_err;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata;
  logic [1:0]  e_count;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  ibex_rf_write_arbiter #(.DataWidth(32), .Depth(2), .RV32E(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .pri_we_i(pri_we), .pri_waddr_i(pri_waddr), .pri_wdata_i(pri_wdata),
    .sec_valid_i(sec_valid), .sec_ready_o(sec_ready),
    .sec_waddr_i(sec_waddr), .sec_wdata_i(sec_wdata),
    .chk_raddr_a_i(chk_a), .chk_raddr_b_i(chk_b),
    .hazard_a_o(hz_a), .hazard_b_o(hz_b),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .count_o(count), .err_o(err)
  );

  ibex_rf_write_arbiter #(.DataWidth(32), .Depth(2), .RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst),
    .pri_we_i(pri_we), .pri_waddr_i(pri_waddr), .pri_wdata_i(pri_wdata),
    .sec_valid_i(sec_valid), .sec_ready_o(e_sec_ready),
    .sec_waddr_i(sec_waddr), .sec_wdata_i(sec_wdata),
    .chk_raddr_a_i(chk_a), .chk_raddr_b_i(chk_b),
    .hazard_a_o(e_hz_a), .hazard_b_o(e_hz_b),
    .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
    .count_o(e_count), .err_o(e_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    pri_we = pwe; pri_waddr = pa; pri_wdata = pd;
    sec_valid = sv; sec_waddr = sa; sec_wdata = sd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678);
    chk_a = 5'd0; chk_b = 5'd0;
    #3;
    sb.push_back('{1'b0, 5'd0, 32'd0});
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL reset_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if (sec_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", sec_ready); else n_pass++;
    n_chk++; if (count !== 2'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_chk++; if ({hz_a, hz_b, err} !== 3'b000) $display("FAIL reset_hz_err: got %b want 000", {hz_a, hz_b, err}); else n_pass++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5A5A5);
    sb.push_back('{1'b1, 5'd5, 32'hA5A5A5A5});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL bypass_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if (count !== 2'd0) $display("FAIL bypass_count: got %0d want 0", count); else n_pass++;
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_chk++; if (count !== 2'd0) $display("FAIL bypass_count_after: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_collision();
    next_cycle();
    chk_a = 5'd7;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    sb.push_back('{1'b1, 5'd3, 32'h11});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL coll_c0_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if (hz_a !== 1'b0) $display("FAIL coll_c0_hz: got %b want 0", hz_a); else n_pass++;
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    sb.push_back('{1'b1, 5'd7, 32'h22});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL coll_c1_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if ({hz_a, count} !== {1'b1, 2'd1}) $display("FAIL coll_c1_hz_count: got %b/%0d want 1/1", hz_a, count); else n_pass++;
    next_cycle();
    sb.push_back('{1'b0, 5'd0, 32'd0});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL coll_c2_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if ({hz_a, count} !== {1'b0, 2'd0}) $display("FAIL coll_c2_hz_count: got %b/%0d want 0/0", hz_a, count); else n_pass++;
    chk_a = 5'd0;
  endtask

  task automatic test_fill();
    logic        t_pwe [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [4:0]  t_pa  [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    logic        t_sv  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [4:0]  t_sa  [8] = '{8, 9, 10, 10, 10, 10, 0, 0};
    logic        x_we  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0]  x_a   [8] = '{1, 2, 3, 4, 8, 9, 10, 0};
    logic        x_rdy [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic [1:0]  x_cnt [8] = '{0, 1, 2, 2, 2, 1, 1, 0};
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      drive(t_pwe[c], t_pa[c], {24'd0, 3'd0, t_pa[c]} * 32'h101,
            t_sv[c], t_sa[c], {24'd0, 3'd0, t_sa[c]} * 32'h101);
      sb.push_back('{x_we[c], x_a[c], x_we[c] ? {24'd0, 3'd0, x_a[c]} * 32'h101 : 32'd0});
      @(negedge clk);
      e = sb.pop_front();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL fill_rf c%0d: got %h want %h", c, {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
      n_chk++; if ({sec_ready, count} !== {x_rdy[c], x_cnt[c]}) $display("FAIL fill_ready_count c%0d: got %b/%0d want %b/%0d", c, sec_ready, count, x_rdy[c], x_cnt[c]); else n_pass++;
    end
  endtask

  task automatic test_waw();
    next_cycle();
    chk_a = 5'd12; chk_b = 5'd12;
    drive(1'b1, 5'd1, 32'h111, 1'b1, 5'd12, 32'h33);
    sb.push_back('{1'b1, 5'd1, 32'h111});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL waw_c0_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    next_cycle();
    drive(1'b1, 5'd12, 32'h44, 1'b0, 5'd0, 32'd0);
    sb.push_back('{1'b1, 5'd12, 32'h44});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL waw_c1_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if ({hz_a, hz_b, count} !== {2'b11, 2'd1}) $display("FAIL waw_c1_hz_count: got %b%b/%0d want 11/1", hz_a, hz_b, count); else n_pass++;
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    sb.push_back('{1'b0, 5'd12, 32'h33});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL waw_killed_pop: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if ({hz_a, count} !== {1'b0, 2'd1}) $display("FAIL waw_c2_hz_count: got %b/%0d want 0/1", hz_a, count); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (count !== 2'd0) $display("FAIL waw_drained: got %0d want 0", count); else n_pass++;
    chk_a = 5'd0; chk_b = 5'd0;
  endtask

  task automatic test_x0();
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    sb.push_back('{1'b0, 5'd0, 32'd0});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL x0_sec_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if ({sec_ready, err} !== 2'b10) $display("FAIL x0_sec_ready_err: got %b want 10", {sec_ready, err}); else n_pass++;
    next_cycle();
    drive(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0);
    sb.push_back('{1'b0, 5'd0, 32'd0});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL x0_pri_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if (count !== 2'd0) $display("FAIL x0_count: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_rv32e();
    next_cycle();
    drive(1'b1, 5'd20, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    sb.push_back('{1'b1, 5'd20, 32'hDEAD});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL rv32i_pri20_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if ({e_rf_we, e_err, err} !== 3'b010) $display("FAIL rv32e_pri20: got we/err/i_err %b want 010", {e_rf_we, e_err, err}); else n_pass++;
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hBEEF);
    sb.push_back('{1'b1, 5'd20, 32'hBEEF});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL rv32i_sec20_rf: got %h want %h", {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    n_chk++; if ({e_rf_we, e_err, e_sec_ready} !== 3'b011) $display("FAIL rv32e_sec20: got we/err/ready %b want 011", {e_rf_we, e_err, e_sec_ready}); else n_pass++;
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_chk++; if ({e_err, e_count} !== 3'b000) $display("FAIL rv32e_after: got err/count %b/%0d want 0/0", e_err, e_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(1'b1, 5'(c + 1), 32'h900 + c, c < 2, 5'(c + 4), 32'h700 + c);
      sb.push_back('{1'b1, 5'(c + 1), 32'h900 + c});
      @(negedge clk);
      e = sb.pop_front();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== e) $display("FAIL rmid_fill_rf c%0d: got %h want %h", c, {rf_we, rf_waddr, rf_wdata}, e); else n_pass++;
    end
    n_chk++; if ({sec_ready, count} !== {1'b0, 2'd2}) $display("FAIL rmid_full: got %b/%0d want 0/2", sec_ready, count); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_chk++; if ({rf_we, sec_ready, count} !== {1'b0, 1'b1, 2'd0}) $display("FAIL rmid_async: got we/ready/count %b/%b/%0d want 0/1/0", rf_we, sec_ready, count); else n_pass++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      sb.push_back('{1'b0, 5'd0, 32'd0});
      @(negedge clk);
      e = sb.pop_front();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata, count} !== {e, 2'd0}) $display("FAIL rmid_after c%0d: got %h/%0d want %h/0", c, {rf_we, rf_waddr, rf_wdata}, count, e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_fill();
    test_waw();
    test_x0();
    test_rv32e();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
